// File: rtl/interrupt_controller.sv
// Nesting interrupt controller: arbitrates exceptions, syscalls and external IRQs at
// instruction boundaries, drives the PC jump mux and keeps a {return PC, level} context stack.
module interrupt_controller #(
  parameter int          N_SRC      = 4,
  parameter int          ADDR_W     = 10,
  parameter int          DEPTH      = 4,
  parameter int unsigned VEC_BASE   = 32'h3C0,
  parameter int unsigned VEC_STRIDE = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_boundary,
  input  logic [N_SRC-1:0]  i_irq,
  input  logic              i_except_req,
  input  logic              i_sys_req,
  input  logic [7:0]        i_sys_num,
  input  logic              i_reti,
  input  logic [ADDR_W-1:0] i_ret_pc,
  input  logic              i_mask_we,
  input  logic [N_SRC-1:0]  i_mask_wdata,
  output logic              o_take,
  output logic [ADDR_W-1:0] o_vector,
  output logic              o_ret_take,
  output logic [ADDR_W-1:0] o_ret_addr,
  output logic [7:0]        o_sys_id,
  output logic [N_SRC-1:0]  o_pending,
  output logic [3:0]        o_level,
  output logic              o_ovf,
  output logic              o_unf
);
  localparam int         SPW        = $clog2(DEPTH) + 1;
  localparam int         PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LVL_EXC    = 4'(N_SRC + 2);
  localparam logic [3:0] LVL_SYS    = 4'(N_SRC + 1);
  localparam logic [3:0] SLOT_FAULT = 4'(N_SRC + 2);

  logic [N_SRC-1:0]             r_sync1, r_sync2, r_sync3, r_pending, r_mask;
  logic [3:0]                   r_level;
  logic [SPW-1:0]               r_sp;
  logic [DEPTH-1:0][ADDR_W-1:0] r_stk_addr;
  logic [DEPTH-1:0][3:0]        r_stk_lvl;
  logic [7:0]                   r_sys_id;
  logic                         r_ovf, r_unf;

  logic [N_SRC-1:0] w_edge, w_clr, w_irq_oh;
  logic             w_full, w_empty, w_arb, w_take, w_push, w_fault, w_sys_win, w_irq_hit;
  logic             w_ret, w_unf_set;
  logic [3:0]       w_slot, w_win_lvl, w_irq_slot, w_irq_lvl;
  logic [PW-1:0]    w_sp_idx, w_top_idx;

  assign w_edge    = r_sync2 & ~r_sync3;
  assign w_full    = (r_sp == SPW'(DEPTH));
  assign w_empty   = (r_sp == '0);
  assign w_sp_idx  = r_sp[PW-1:0];
  assign w_top_idx = PW'(r_sp - SPW'(1));
  assign w_arb     = i_boundary & ~i_reti;
  assign w_ret     = i_boundary & i_reti & ~w_empty;
  assign w_unf_set = i_boundary & i_reti & w_empty;

  // Lowest-index eligible IRQ is also the highest-level one.
  always_comb begin
    w_irq_hit  = 1'b0;
    w_irq_oh   = '0;
    w_irq_slot = '0;
    w_irq_lvl  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (!w_irq_hit && r_pending[i] && r_mask[i] && (r_level < 4'(N_SRC - i))) begin
        w_irq_hit   = 1'b1;
        w_irq_oh    = '0;
        w_irq_oh[i] = 1'b1;
        w_irq_slot  = 4'(2 + i);
        w_irq_lvl   = 4'(N_SRC - i);
      end
    end
  end

  // A full stack still lets an exception through, but only to the fault vector.
  always_comb begin
    w_take    = 1'b0;
    w_push    = 1'b0;
    w_fault   = 1'b0;
    w_sys_win = 1'b0;
    w_clr     = '0;
    w_slot    = '0;
    w_win_lvl = r_level;
    if (w_arb) begin
      if (i_except_req) begin
        w_take = 1'b1;
        if (w_full) begin
          w_fault = 1'b1;
          w_slot  = SLOT_FAULT;
        end else begin
          w_push    = 1'b1;
          w_win_lvl = LVL_EXC;
        end
      end else if (i_sys_req && (r_level < LVL_SYS)) begin
        if (!w_full) begin
          w_take    = 1'b1;
          w_push    = 1'b1;
          w_sys_win = 1'b1;
          w_slot    = 4'd1;
          w_win_lvl = LVL_SYS;
        end
      end else if (w_irq_hit && !w_full) begin
        w_take    = 1'b1;
        w_push    = 1'b1;
        w_clr     = w_irq_oh;
        w_slot    = w_irq_slot;
        w_win_lvl = w_irq_lvl;
      end
    end
  end

  assign o_take     = w_take;
  assign o_vector   = ADDR_W'(VEC_BASE + 32'(w_slot) * VEC_STRIDE);
  assign o_ret_take = w_ret;
  assign o_ret_addr = w_empty ? '0 : r_stk_addr[w_top_idx];
  assign o_sys_id   = r_sys_id;
  assign o_pending  = r_pending;
  assign o_level    = r_level;
  assign o_ovf      = r_ovf;
  assign o_unf      = r_unf;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_sync3   <= '0;
      r_pending <= '0;
      r_mask    <= '0;
    end else begin
      r_sync1   <= i_irq;
      r_sync2   <= r_sync1;
      r_sync3   <= r_sync2;
      r_pending <= (r_pending & ~w_clr) | w_edge;
      if (i_mask_we) r_mask <= i_mask_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_level    <= '0;
      r_sp       <= '0;
      r_stk_addr <= '0;
      r_stk_lvl  <= '0;
    end else if (w_push) begin
      r_stk_addr[w_sp_idx] <= i_ret_pc;
      r_stk_lvl[w_sp_idx]  <= r_level;
      r_sp                 <= r_sp + SPW'(1);
      r_level              <= w_win_lvl;
    end else if (w_ret) begin
      r_sp    <= r_sp - SPW'(1);
      r_level <= r_stk_lvl[w_top_idx];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sys_id <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_sys_win) r_sys_id <= i_sys_num;
      if (w_fault)   r_ovf    <= 1'b1;
      if (w_unf_set) r_unf    <= 1'b1;
    end
  end
endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: one vector record per clock cycle, inputs driven
// after the falling edge and outputs/state compared 1 ns later.
module tb_interrupt_controller;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       boundary, except_req, sys_req, reti, mask_we;
  logic [3:0] irq, mask_wdata;
  logic [7:0] sys_num;
  logic [9:0] ret_pc;
  logic       take, ret_take, ovf, unf;
  logic [9:0] vector, ret_addr;
  logic [7:0] sys_id;
  logic [3:0] pending, level;

  int n_chk = 0;
  int n_err = 0;

  // inputs: bnd irq exc sys snum reti pc mwe mask | expected: take vec rtake raddr lvl pend sid ovf unf
  typedef struct {
    logic bnd; logic [3:0] irq; logic exc; logic sys; logic [7:0] snum; logic reti;
    logic [9:0] pc; logic mwe; logic [3:0] mask;
    logic take; logic [9:0] vec; logic rtake; logic [9:0] raddr; logic [3:0] lvl;
    logic [3:0] pend; logic [7:0] sid; logic ovf; logic unf;
  } vec_t;

  vec_t tbl [28];

  always #5 clk = ~clk;

  interrupt_controller dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_boundary(boundary), .i_irq(irq),
    .i_except_req(except_req), .i_sys_req(sys_req), .i_sys_num(sys_num), .i_reti(reti),
    .i_ret_pc(ret_pc), .i_mask_we(mask_we), .i_mask_wdata(mask_wdata),
    .o_take(take), .o_vector(vector), .o_ret_take(ret_take), .o_ret_addr(ret_addr),
    .o_sys_id(sys_id), .o_pending(pending), .o_level(level), .o_ovf(ovf), .o_unf(unf)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    boundary   = x.bnd;  irq     = x.irq;  except_req = x.exc; sys_req = x.sys;
    sys_num    = x.snum; reti    = x.reti; ret_pc     = x.pc;  mask_we = x.mwe;
    mask_wdata = x.mask;
  endtask

  task automatic run(input vec_t x, input string tag);
    @(negedge clk);
    drive(x);
    #1;
    chk({tag, " take"}, 32'(take), 32'(x.take));
    if (x.take) chk({tag, " vector"}, 32'(vector), 32'(x.vec));
    chk({tag, " ret_take"}, 32'(ret_take), 32'(x.rtake));
    chk({tag, " ret_addr"}, 32'(ret_addr), 32'(x.raddr));
    chk({tag, " level"},    32'(level),    32'(x.lvl));
    chk({tag, " pending"},  32'(pending),  32'(x.pend));
    chk({tag, " sys_id"},   32'(sys_id),   32'(x.sid));
    chk({tag, " ovf"},      32'(ovf),      32'(x.ovf));
    chk({tag, " unf"},      32'(unf),      32'(x.unf));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " take"},     32'(take),     32'd0);
    chk({tag, " ret_take"}, 32'(ret_take), 32'd0);
    chk({tag, " ret_addr"}, 32'(ret_addr), 32'd0);
    chk({tag, " level"},    32'(level),    32'd0);
    chk({tag, " pending"},  32'(pending),  32'd0);
    chk({tag, " sys_id"},   32'(sys_id),   32'd0);
    chk({tag, " ovf"},      32'(ovf),      32'd0);
    chk({tag, " unf"},      32'(unf),      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    vec_t z;
    z = '{1'b0,4'h0,1'b0,1'b0,8'h00,1'b0,10'h000,1'b0,4'h0, 1'b0,10'h000,1'b0,10'h000,4'd0,4'h0,8'h00,1'b0,1'b0};
    // Nesting of irq[2] / irq[0] / irq[3], then exception vs syscall vs irq[0].
    tbl[0]  = '{1'b0,4'h0,1'b0,1'b0,8'h00,1'b0,10'h000,1'b1,4'hF, 1'b0,10'h000,1'b0,10'h000,4'd0,4'h0,8'h00,1'b0,1'b0};
    tbl[1]  = '{1'b0,4'h4,1'b0,1'b0,8'h00,1'b0,10'h000,1'b0,4'h0, 1'b0,10'h000,1'b0,10'h000,4'd0,4'h0,8'h00,1'b0,1'b0};
    tbl[2]  = '{1'b0,4'h0,1'b0,1'b0,8'h00,1'b0,10'h000,1'b0,4'h0, 1'b0,10'h000,1'b0,10'h000,4'd0,4'h0,8'h00,1'b0,1'b0};
    tbl[3]  = '{1'b0,4'h0,1'b0,1'b0,8'h00,1'b0,10'h000,1'b0,4'h0, 1'b0,10'h000,1'b0,10'h000,4'd0,4'h0,8'h00,1'b0,1'b0};
    tbl[4]  = '{1'b1,4'h0,1'b0,1'b0,8'h00,1'b0,10'h010,1'b0,4'h0, 1'b1,10'h3D0,1'b0,10'h000,4'd0,4'h4,8'h00,1'b0,1'b0};
    tbl[5]  = '{1'b0,4'h9,1'b0,1'b0,8'h00,1'b0,10'h000,1'b0,4'h0, 1'b0,10'h000,1'b0,10'h010,4'd2,4'h0,8'h00,1'b0,1'b0};
    tbl[6]  = '{1'b0,4'h9,1'b0,1'b0,8'h00,1'b0,10'h000,1'b0,4'h0, 1'b0,10'h000,1'b0,10'h010,4'd2,4'h0,8'h00,1'b0,1'b0};
    tbl[7]  = '{1'b0,4'h9,1'b0,1'b0,8'h00,1'b0,10'h000,1'b0,4'h0, 1'b0,10'h000,1'b0,10'h010,4'd2,4'h0,8'h00,1'b0,1'b0};
    tbl[8]  = '{1'b1,4'h0,1'b0,1'b0,8'h00,1'b0,10'h020,1'b0,4'h0, 1'b1,10'h3C8,1'b0,10'h010,4'd2,4'h9,8'h00,1'b0,1'b0};
    tbl[9]  = '{1'b1,4'h0,1'b0,1'b0,8'h00,1'b0,10'h030,1'b0,4'h0, 1'b0,10'h000,1'b0,10'h020,4'd4,4'h8,8'h00,1'b0,1'b0};
    tbl[10] = '{1'b1,4'h0,1'b0,1'b0,8'h00,1'b1,10'h000,1'b0,4'h0, 1'b0,10'h000,1'b1,10'h020,4'd4,4'h8,8'h00,1'b0,1'b0};
    tbl[11] = '{1'b0,4'h0,1'b0,1'b0,8'h00,1'b0,10'h000,1'b0,4'h0, 1'b0,10'h000,1'b0,10'h010,4'd2,4'h8,8'h00,1'b0,1'b0};
    tbl[12] = '{1'b1,4'h0,1'b0,1'b0,8'h00,1'b1,10'h000,1'b0,4'h0, 1'b0,10'h000,1'b1,10'h010,4'd2,4'h8,8'h00,1'b0,1'b0};
    tbl[13] = '{1'b1,4'h0,1'b0,1'b0,8'h00,1'b0,10'h040,1'b0,4'h0, 1'b1,10'h3D4,1'b0,10'h000,4'd0,4'h8,8'h00,1'b0,1'b0};
    tbl[14] = '{1'b1,4'h0,1'b0,1'b0,8'h00,1'b1,10'h000,1'b0,4'h0, 1'b0,10'h000,1'b1,10'h040,4'd1,4'h0,8'h00,1'b0,1'b0};
    tbl[15] = '{1'b0,4'h0,1'b0,1'b0,8'h00,1'b0,10'h000,1'b0,4'h0, 1'b0,10'h000,1'b0,10'h000,4'd0,4'h0,8'h00,1'b0,1'b0};
    tbl[16] = '{1'b0,4'h1,1'b0,1'b0,8'h00,1'b0,10'h000,1'b0,4'h0, 1'b0,10'h000,1'b0,10'h000,4'd0,4'h0,8'h00,1'b0,1'b0};
    tbl[17] = '{1'b0,4'h0,1'b0,1'b0,8'h00,1'b0,10'h000,1'b0,4'h0, 1'b0,10'h000,1'b0,10'h000,4'd0,4'h0,8'h00,1'b0,1'b0};
    tbl[18] = '{1'b0,4'h0,1'b0,1'b0,8'h00,1'b0,10'h000,1'b0,4'h0, 1'b0,10'h000,1'b0,10'h000,4'd0,4'h0,8'h00,1'b0,1'b0};
    tbl[19] = '{1'b1,4'h0,1'b1,1'b1,8'h2A,1'b0,10'h050,1'b0,4'h0, 1'b1,10'h3C0,1'b0,10'h000,4'd0,4'h1,8'h00,1'b0,1'b0};
    tbl[20] = '{1'b1,4'h0,1'b0,1'b1,8'h2A,1'b0,10'h060,1'b0,4'h0, 1'b0,10'h000,1'b0,10'h050,4'd6,4'h1,8'h00,1'b0,1'b0};
    tbl[21] = '{1'b1,4'h0,1'b0,1'b0,8'h00,1'b1,10'h000,1'b0,4'h0, 1'b0,10'h000,1'b1,10'h050,4'd6,4'h1,8'h00,1'b0,1'b0};
    tbl[22] = '{1'b1,4'h0,1'b0,1'b1,8'h2A,1'b0,10'h060,1'b0,4'h0, 1'b1,10'h3C4,1'b0,10'h000,4'd0,4'h1,8'h00,1'b0,1'b0};
    tbl[23] = '{1'b0,4'h0,1'b0,1'b0,8'h00,1'b0,10'h000,1'b0,4'h0, 1'b0,10'h000,1'b0,10'h060,4'd5,4'h1,8'h2A,1'b0,1'b0};
    tbl[24] = '{1'b1,4'h0,1'b0,1'b0,8'h00,1'b1,10'h000,1'b0,4'h0, 1'b0,10'h000,1'b1,10'h060,4'd5,4'h1,8'h2A,1'b0,1'b0};
    tbl[25] = '{1'b1,4'h0,1'b0,1'b0,8'h00,1'b0,10'h070,1'b0,4'h0, 1'b1,10'h3C8,1'b0,10'h000,4'd0,4'h1,8'h2A,1'b0,1'b0};
    tbl[26] = '{1'b1,4'h0,1'b0,1'b0,8'h00,1'b1,10'h000,1'b0,4'h0, 1'b0,10'h000,1'b1,10'h070,4'd4,4'h0,8'h2A,1'b0,1'b0};
    tbl[27] = '{1'b0,4'h0,1'b0,1'b0,8'h00,1'b0,10'h000,1'b0,4'h0, 1'b0,10'h000,1'b0,10'h000,4'd0,4'h0,8'h2A,1'b0,1'b0};

    drive(z);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 chk_reset("reset");
    #4 rst_n = 1'b1;

    for (int i = 0; i < 28; i++) run(tbl[i], $sformatf("row%0d", i));

    // A fresh irq[1] edge landing in the cycle its pending bit is taken keeps it pending.
    run('{1'b0,4'h2,1'b0,1'b0,8'h00,1'b0,10'h000,1'b0,4'h0, 1'b0,10'h000,1'b0,10'h000,4'd0,4'h0,8'h2A,1'b0,1'b0}, "setwin1");
    run('{1'b0,4'h0,1'b0,1'b0,8'h00,1'b0,10'h000,1'b0,4'h0, 1'b0,10'h000,1'b0,10'h000,4'd0,4'h0,8'h2A,1'b0,1'b0}, "setwin2");
    run('{1'b0,4'h2,1'b0,1'b0,8'h00,1'b0,10'h000,1'b0,4'h0, 1'b0,10'h000,1'b0,10'h000,4'd0,4'h0,8'h2A,1'b0,1'b0}, "setwin3");
    run('{1'b0,4'h0,1'b0,1'b0,8'h00,1'b0,10'h000,1'b0,4'h0, 1'b0,10'h000,1'b0,10'h000,4'd0,4'h2,8'h2A,1'b0,1'b0}, "setwin4");
    run('{1'b1,4'h0,1'b0,1'b0,8'h00,1'b0,10'h080,1'b0,4'h0, 1'b1,10'h3CC,1'b0,10'h000,4'd0,4'h2,8'h2A,1'b0,1'b0}, "setwin5");
    run('{1'b1,4'h0,1'b0,1'b0,8'h00,1'b1,10'h000,1'b0,4'h0, 1'b0,10'h000,1'b1,10'h080,4'd3,4'h2,8'h2A,1'b0,1'b0}, "setwin6");
    run('{1'b1,4'h0,1'b0,1'b0,8'h00,1'b0,10'h090,1'b0,4'h0, 1'b1,10'h3CC,1'b0,10'h000,4'd0,4'h2,8'h2A,1'b0,1'b0}, "setwin7");
    run('{1'b1,4'h0,1'b0,1'b0,8'h00,1'b1,10'h000,1'b0,4'h0, 1'b0,10'h000,1'b1,10'h090,4'd3,4'h0,8'h2A,1'b0,1'b0}, "setwin8");
    run('{1'b0,4'h0,1'b0,1'b0,8'h00,1'b0,10'h000,1'b0,4'h0, 1'b0,10'h000,1'b0,10'h000,4'd0,4'h0,8'h2A,1'b0,1'b0}, "setwin9");

    // Four nested exceptions fill the stack; the fifth goes to the fault slot.
    run('{1'b1,4'h0,1'b1,1'b0,8'h00,1'b0,10'h100,1'b0,4'h0, 1'b1,10'h3C0,1'b0,10'h000,4'd0,4'h0,8'h2A,1'b0,1'b0}, "ovf1");
    run('{1'b1,4'h0,1'b1,1'b0,8'h00,1'b0,10'h101,1'b0,4'h0, 1'b1,10'h3C0,1'b0,10'h100,4'd6,4'h0,8'h2A,1'b0,1'b0}, "ovf2");
    run('{1'b1,4'h0,1'b1,1'b0,8'h00,1'b0,10'h102,1'b0,4'h0, 1'b1,10'h3C0,1'b0,10'h101,4'd6,4'h0,8'h2A,1'b0,1'b0}, "ovf3");
    run('{1'b1,4'h0,1'b1,1'b0,8'h00,1'b0,10'h103,1'b0,4'h0, 1'b1,10'h3C0,1'b0,10'h102,4'd6,4'h0,8'h2A,1'b0,1'b0}, "ovf4");
    run('{1'b1,4'h0,1'b1,1'b0,8'h00,1'b0,10'h104,1'b0,4'h0, 1'b1,10'h3D8,1'b0,10'h103,4'd6,4'h0,8'h2A,1'b0,1'b0}, "ovf5");
    run('{1'b1,4'h0,1'b0,1'b0,8'h00,1'b1,10'h000,1'b0,4'h0, 1'b0,10'h000,1'b1,10'h103,4'd6,4'h0,8'h2A,1'b1,1'b0}, "pop4");
    run('{1'b1,4'h0,1'b0,1'b0,8'h00,1'b1,10'h000,1'b0,4'h0, 1'b0,10'h000,1'b1,10'h102,4'd6,4'h0,8'h2A,1'b1,1'b0}, "pop3");
    run('{1'b1,4'h0,1'b0,1'b0,8'h00,1'b1,10'h000,1'b0,4'h0, 1'b0,10'h000,1'b1,10'h101,4'd6,4'h0,8'h2A,1'b1,1'b0}, "pop2");
    run('{1'b1,4'h0,1'b0,1'b0,8'h00,1'b1,10'h000,1'b0,4'h0, 1'b0,10'h000,1'b1,10'h100,4'd6,4'h0,8'h2A,1'b1,1'b0}, "pop1");
    // Empty-stack RETI underflows and also suppresses a pending irq[0] for that cycle.
    run('{1'b0,4'h1,1'b0,1'b0,8'h00,1'b0,10'h000,1'b0,4'h0, 1'b0,10'h000,1'b0,10'h000,4'd0,4'h0,8'h2A,1'b1,1'b0}, "unf1");
    run('{1'b0,4'h0,1'b0,1'b0,8'h00,1'b0,10'h000,1'b0,4'h0, 1'b0,10'h000,1'b0,10'h000,4'd0,4'h0,8'h2A,1'b1,1'b0}, "unf2");
    run('{1'b0,4'h0,1'b0,1'b0,8'h00,1'b0,10'h000,1'b0,4'h0, 1'b0,10'h000,1'b0,10'h000,4'd0,4'h0,8'h2A,1'b1,1'b0}, "unf3");
    run('{1'b1,4'h0,1'b0,1'b0,8'h00,1'b1,10'h000,1'b0,4'h0, 1'b0,10'h000,1'b0,10'h000,4'd0,4'h1,8'h2A,1'b1,1'b0}, "unf4");
    run('{1'b1,4'h0,1'b0,1'b0,8'h00,1'b0,10'h0A0,1'b0,4'h0, 1'b1,10'h3C8,1'b0,10'h000,4'd0,4'h1,8'h2A,1'b1,1'b1}, "unf5");
    run('{1'b1,4'h0,1'b0,1'b0,8'h00,1'b1,10'h000,1'b0,4'h0, 1'b0,10'h000,1'b1,10'h0A0,4'd4,4'h0,8'h2A,1'b1,1'b1}, "unf6");

    // Three-deep nest, then an asynchronous reset between clock edges.
    run('{1'b1,4'h0,1'b1,1'b0,8'h00,1'b0,10'h0B0,1'b0,4'h0, 1'b1,10'h3C0,1'b0,10'h000,4'd0,4'h0,8'h2A,1'b1,1'b1}, "nest1");
    run('{1'b1,4'h0,1'b1,1'b0,8'h00,1'b0,10'h0B1,1'b0,4'h0, 1'b1,10'h3C0,1'b0,10'h0B0,4'd6,4'h0,8'h2A,1'b1,1'b1}, "nest2");
    run('{1'b1,4'h0,1'b1,1'b0,8'h00,1'b0,10'h0B2,1'b0,4'h0, 1'b1,10'h3C0,1'b0,10'h0B1,4'd6,4'h0,8'h2A,1'b1,1'b1}, "nest3");
    run('{1'b0,4'h0,1'b0,1'b0,8'h00,1'b0,10'h000,1'b0,4'h0, 1'b0,10'h000,1'b0,10'h0B2,4'd6,4'h0,8'h2A,1'b1,1'b1}, "nest4");
    #1 rst_n = 1'b0;
    #1 chk_reset("async_reset");
    #1 rst_n = 1'b1;

    // Mask is cleared by reset: pending latches but is not taken until the mask write lands.
    run('{1'b0,4'h1,1'b0,1'b0,8'h00,1'b0,10'h000,1'b0,4'h0, 1'b0,10'h000,1'b0,10'h000,4'd0,4'h0,8'h00,1'b0,1'b0}, "post1");
    run('{1'b0,4'h0,1'b0,1'b0,8'h00,1'b0,10'h000,1'b0,4'h0, 1'b0,10'h000,1'b0,10'h000,4'd0,4'h0,8'h00,1'b0,1'b0}, "post2");
    run('{1'b0,4'h0,1'b0,1'b0,8'h00,1'b0,10'h000,1'b0,4'h0, 1'b0,10'h000,1'b0,10'h000,4'd0,4'h0,8'h00,1'b0,1'b0}, "post3");
    run('{1'b1,4'h0,1'b0,1'b0,8'h00,1'b0,10'h0C0,1'b0,4'h0, 1'b0,10'h000,1'b0,10'h000,4'd0,4'h1,8'h00,1'b0,1'b0}, "post4");
    run('{1'b1,4'h0,1'b0,1'b0,8'h00,1'b0,10'h0C0,1'b1,4'h1, 1'b0,10'h000,1'b0,10'h000,4'd0,4'h1,8'h00,1'b0,1'b0}, "post5");
    run('{1'b1,4'h0,1'b0,1'b0,8'h00,1'b0,10'h0D0,1'b0,4'h0, 1'b1,10'h3C8,1'b0,10'h000,4'd0,4'h1,8'h00,1'b0,1'b0}, "post6");
    run('{1'b0,4'h0,1'b0,1'b0,8'h00,1'b0,10'h000,1'b0,4'h0, 1'b0,10'h000,1'b0,10'h0D0,4'd4,4'h0,8'h00,1'b0,1'b0}, "post7");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
